// File: rtl/saida_buffer.sv
// ============================================================================
// Module   : saida_buffer
// Brief    : FIFO that records each value loaded into the output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module saida_buffer #(
  parameter int         DEPTH   = 8,
  parameter logic [4:0] TZ_LOAD = 5'd1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4:0]               tz,
  input  logic [4:0]               saida,
  output logic [4:0]               dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_pending;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_rd;
  logic          w_wr;
  logic          w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // The capture lags tz by one cycle so that saida already holds the new value.
  assign w_rd   = !w_empty && dout_ready;
  assign w_wr   = r_pending && (!w_full || w_rd);
  assign w_drop = r_pending && !w_wr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= (tz == TZ_LOAD);
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; stale contents are hidden by the empty mask on dout.
  always_ff @(posedge clock) begin
    if (!reset && w_wr) begin
      r_mem[r_wr_ptr] <= saida;
    end
  end

  assign dout       = w_empty ? 5'd0 : r_mem[r_rd_ptr];
  assign dout_valid = !w_empty;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_saida_buffer.sv
// ============================================================================
// Module   : tb_saida_buffer
// Brief    : Randomized self-checking bench for saida_buffer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_saida_buffer;

  localparam int         DEPTH   = 8;
  localparam logic [4:0] TZ_LOAD = 5'd1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] tz = 5'd0;
  logic [4:0] saida = 5'd0;
  logic [4:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of stored values plus the pending and sticky flags.
  logic [4:0] mq[$];
  logic [4:0] got[$];
  logic       m_pend = 1'b0;
  logic       m_ovf  = 1'b0;

  saida_buffer #(.DEPTH(DEPTH), .TZ_LOAD(TZ_LOAD)) dut (
    .clock      (clock),
    .reset      (reset),
    .tz         (tz),
    .saida      (saida),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance the model over the edge, return at negedge.
  task automatic step(input logic [4:0] t, input logic [4:0] s, input logic r, input logic rs);
    logic m_rd;
    logic m_wr;
    tz = t; saida = s; dout_ready = r; reset = rs;
    m_rd = !rs && (mq.size() > 0) && r;
    m_wr = !rs && m_pend && ((mq.size() < DEPTH) || m_rd);
    if (m_rd) got.push_back(dout);
    @(posedge clock);
    if (rs) begin
      mq.delete();
      m_pend = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (m_rd) void'(mq.pop_front());
      if (m_wr) mq.push_back(s);
      if (m_pend && !m_wr) m_ovf = 1'b1;
      m_pend = (t == TZ_LOAD);
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      step(5'd0, 5'd0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain: count=%0d empty=%0b, required count=0 empty=1", count, empty);
    end
  endtask

  task automatic test_reset();
    step(5'd0, 5'd0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || dout_valid !== 1'b0 || overflow !== 1'b0 ||
        dout !== 5'd0 || count !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: empty=%0b full=%0b valid=%0b ovf=%0b dout=%0d count=%0d, required 1 0 0 0 0 0",
               empty, full, dout_valid, overflow, dout, count);
    end
  endtask

  task automatic test_basic();
    step(TZ_LOAD, 5'd0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pending: count=%0d valid=%0b, required 0 0", count, dout_valid);
    end
    step(5'd0, 5'd7, 1'b0, 1'b0);
    checks++;
    if (dout !== 5'd7 || dout_valid !== 1'b1 || count !== 4'd1) begin
      errors++;
      $display("FAIL basic_capture: dout=%0d valid=%0b count=%0d, required 7 1 1", dout, dout_valid, count);
    end
    step(5'd0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL basic_read: empty=%0b count=%0d, required 1 0", empty, count);
    end
  endtask

  task automatic test_order_wrap();
    step(5'd0, 5'd0, 1'b0, 1'b1);
    got.delete();
    for (int j = 0; j <= 12; j++) begin
      step((j < 12) ? TZ_LOAD : 5'd0, 5'(j), 1'(j % 2), 1'b0);
      checks++;
      if (count > 4'd8 || overflow !== 1'b0 || count !== 4'(mq.size())) begin
        errors++;
        $display("FAIL wrap_cycle%0d: count=%0d ovf=%0b, required count=%0d ovf=0", j, count, overflow, mq.size());
      end
    end
    drain();
    checks++;
    if (got.size() != 12) begin
      errors++;
      $display("FAIL wrap_len: got %0d entries, required 12", got.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (got[k] !== 5'(k + 1)) begin
          errors++;
          $display("FAIL wrap_order[%0d]: got %0d, required %0d", k, got[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_overflow();
    step(5'd0, 5'd0, 1'b0, 1'b1);
    got.delete();
    for (int j = 0; j <= 9; j++) begin
      step((j < 9) ? TZ_LOAD : 5'd0, (j == 9) ? 5'd31 : 5'(j - 1), 1'b0, 1'b0);
    end
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state: full=%0b count=%0d ovf=%0b, required 1 8 1", full, count, overflow);
    end
    drain();
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL ovf_len: got %0d entries, required 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got[k] !== 5'(k)) begin
          errors++;
          $display("FAIL ovf_order[%0d]: got %0d, required %0d", k, got[k], k);
        end
      end
    end
  endtask

  task automatic test_full_rw();
    logic [4:0] exp_seq [9];
    step(5'd0, 5'd0, 1'b0, 1'b1);
    for (int j = 0; j <= 8; j++) begin
      step(TZ_LOAD, 5'(j + 2), 1'b0, 1'b0);
    end
    checks++;
    if (count !== 4'd8 || dout !== 5'd3) begin
      errors++;
      $display("FAIL fullrw_pre: count=%0d dout=%0d, required 8 3", count, dout);
    end
    got.delete();
    step(5'd0, 5'd20, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd8 || dout !== 5'd4 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL fullrw_post: count=%0d dout=%0d ovf=%0b full=%0b, required 8 4 0 1",
               count, dout, overflow, full);
    end
    drain();
    for (int k = 0; k < 9; k++) exp_seq[k] = (k == 8) ? 5'd20 : 5'(k + 3);
    checks++;
    if (got.size() != 9) begin
      errors++;
      $display("FAIL fullrw_len: got %0d entries, required 9", got.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (got[k] !== exp_seq[k]) begin
          errors++;
          $display("FAIL fullrw_order[%0d]: got %0d, required %0d", k, got[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(5'd0, 5'd0, 1'b0, 1'b1);
    for (int j = 0; j <= 5; j++) begin
      step((j < 5) ? TZ_LOAD : 5'd0, 5'(j + 10), 1'b0, 1'b0);
    end
    step(TZ_LOAD, 5'd0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL rstmid_pre: count=%0d, required 5", count);
    end
    step(5'd0, 5'd25, 1'b0, 1'b1);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || dout !== 5'd0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_post: count=%0d empty=%0b ovf=%0b dout=%0d valid=%0b, required 0 1 0 0 0",
               count, empty, overflow, dout, dout_valid);
    end
    for (int j = 0; j < 3; j++) begin
      step(5'd0, 5'd25, 1'b0, 1'b0);
      checks++;
      if (count !== 4'd0) begin
        errors++;
        $display("FAIL rstmid_idle%0d: count=%0d, required 0", j, count);
      end
    end
  endtask

  task automatic test_non_load();
    logic [4:0] code;
    step(5'd0, 5'd0, 1'b0, 1'b1);
    for (int j = 0; j < 40; j++) begin
      code = 5'(j % 31);
      if (code != 5'd0) code = code + 5'd1;
      step(code, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
      checks++;
      if (count !== 4'd0) begin
        errors++;
        $display("FAIL nonload_%0d: tz=%0d count=%0d, required 0", j, code, count);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] t;
    logic [4:0] e_dout;
    step(5'd0, 5'd0, 1'b0, 1'b1);
    for (int j = 0; j < 600; j++) begin
      t = ($urandom_range(0, 2) != 0) ? TZ_LOAD : 5'($urandom_range(0, 31));
      step(t, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 149) == 0));
      e_dout = (mq.size() > 0) ? mq[0] : 5'd0;
      checks++;
      if (count !== 4'(mq.size()) || dout !== e_dout || dout_valid !== (mq.size() > 0) ||
          full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random_%0d: count=%0d dout=%0d valid=%0b full=%0b empty=%0b ovf=%0b, required count=%0d dout=%0d ovf=%0b",
                 j, count, dout, dout_valid, full, empty, overflow, mq.size(), e_dout, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order_wrap();
    test_overflow();
    test_full_rw();
    test_reset_mid();
    test_non_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/saida_buffer.md
SAIDA_BUFFER -- requirements
Module: saida_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..32.
REQ-002 Parameter TZ_LOAD, default 5'd1, the tz control code that loads the output register.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tz  input  5  output-register control code from the controller.
REQ-006 saida  input  5  output-register value from the datapath.
REQ-007 dout  output  5  FIFO head entry.
REQ-008 dout_valid  output  1  high when dout holds an unread entry.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 overflow  output  1  sticky flag: at least one capture dropped.

Function
REQ-014 Capture request: when tz == TZ_LOAD at a rising edge, a one-bit pending flag SHALL be set for exactly the next cycle; any other tz value clears it.
REQ-015 Capture: in a cycle where pending is high, the current saida value SHALL be written at the tail. This sample is the value the output register loaded on the previous edge.
REQ-016 Back-to-back tz == TZ_LOAD cycles SHALL produce one capture per cycle.
REQ-017 Write acceptance: a capture SHALL be written when !full, or when full and a read occurs in the same cycle.
REQ-018 Drop: a capture with full and no same-cycle read SHALL be discarded, and overflow SHALL set and hold until reset.
REQ-019 Read: when dout_valid && dout_ready, the head SHALL advance by one entry at the edge.
REQ-020 dout_ready while empty SHALL have no effect.
REQ-021 dout_valid SHALL equal !empty.
REQ-022 dout SHALL reflect the head entry combinationally from storage. No fall-through: a capture into an empty FIFO SHALL make dout_valid high on the following cycle, not the same cycle.
REQ-023 Simultaneous read and write SHALL leave count unchanged, including at count == DEPTH and at count == 1.
REQ-024 count SHALL change as follows: +1 on write only, -1 on read only, otherwise unchanged.
REQ-025 count SHALL never exceed DEPTH or go below 0.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-027 FIFO order SHALL be strict: entries leave in capture order.
REQ-028 full, empty and overflow SHALL be registered or derived from registered count, with no combinational path from dout_ready or tz.

Reset
REQ-029 While reset is high at an edge, the block SHALL clear count, both pointers, the pending flag and overflow to 0.
REQ-030 After reset: empty=1, full=0, dout_valid=0, overflow=0.
REQ-031 dout SHALL be 5'd0 after reset. Storage contents need not be cleared, but dout SHALL be masked to 0 while empty.
REQ-032 Reset SHALL take priority over any simultaneous capture or read.
REQ-033 A capture pending at reset SHALL be discarded and SHALL NOT be written after reset deasserts.

Verification
REQ-034 Basic capture: reset; tz=1 for one cycle; saida=5'd7 on the next cycle -> one cycle later dout=7, dout_valid=1, count=1; dout_ready=1 for one cycle -> empty=1, count=0.
REQ-035 Order and wrap: capture 1,2,...,12 with dout_ready pulsed so count stays at or below 8 -> dout sequence is 1..12 with no loss; pointers wrap; overflow stays 0.
REQ-036 Overflow: fill 8 entries (values 0..7) with dout_ready=0, then capture 5'd31 -> full=1, count=8, overflow=1; drain all -> values 0..7, and 31 is absent.
REQ-037 Full with simultaneous read and write: count=8, head=3; capture 5'd20 with dout_ready=1 -> count stays 8, next dout=4, 20 sits last, overflow unchanged.
REQ-038 Reset mid-operation: count=5 with a pending capture; assert reset for one cycle -> count=0, empty=1, overflow=0, dout=0; no entry appears after deassert.
REQ-039 Non-load codes: tz cycles through 0, 2..31 for 40 cycles -> count stays 0 throughout.
